// File: rtl/bcd_pkg.sv
// bcd_pkg: shared BCD digit type, digit limits and load sanitizer.
package bcd_pkg;
   typedef logic [3:0] bcd_digit_t;
   localparam bcd_digit_t BCD_MAX = 4'd9;
   localparam bcd_digit_t BCD_MIN = 4'd0;
   function automatic bcd_digit_t bcd_sanitize(input bcd_digit_t d);
      return (d > BCD_MAX) ? BCD_MIN : d;
   endfunction
endpackage

// File: rtl/bcd_digit_updown.sv
// bcd_digit_updown: one up/down BCD digit with clear, load and terminal flag.
module bcd_digit_updown
   import bcd_pkg::*;
(
   input  logic       clk_i,
   input  logic       rst_n_i,
   input  logic       clear_i,
   input  logic       load_i,
   input  bcd_digit_t load_value_i,
   input  logic       en_i,
   input  logic       down_i,
   output bcd_digit_t digit_o,
   output logic       at_term_o
);
   bcd_digit_t digit_q, digit_d;
   always_comb begin
      digit_d = clear_i ? BCD_MIN :
                load_i  ? bcd_sanitize(load_value_i) :
                !en_i   ? digit_q :
                down_i  ? ((digit_q == BCD_MIN) ? BCD_MAX : digit_q - 4'd1) :
                          ((digit_q == BCD_MAX) ? BCD_MIN : digit_q + 4'd1);
   end
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) digit_q <= BCD_MIN;
      else          digit_q <= digit_d;
   end
   assign digit_o   = digit_q;
   assign at_term_o = (digit_q == (down_i ? BCD_MIN : BCD_MAX));
endmodule

// File: rtl/counter_bcd_ndigit.sv
// counter_bcd_ndigit: N-digit up/down BCD counter with wrap/saturate,
// sticky overflow and a snapshot register for the display path.
module counter_bcd_ndigit
   import bcd_pkg::*;
#(
   parameter int DIGITS   = 6,
   parameter bit SATURATE = 1'b0
) (
   input  logic                clk_in,
   input  logic                reset_n_in,
   input  logic                clear_in,
   input  logic                load_in,
   input  logic [4*DIGITS-1:0] load_value_in,
   input  logic                enable_in,
   input  logic                down_in,
   input  logic                latch_in,
   output logic [4*DIGITS-1:0] count_out,
   output logic                overflow_out,
   output logic                carry_out,
   output logic [4*DIGITS-1:0] latched_out,
   output logic                latched_overflow_out
);
   logic [DIGITS-1:0]   at_term;
   logic                terminal, step_req, step;
   logic                overflow_q, overflow_d, latched_ovf_q, latched_ovf_d;
   logic [4*DIGITS-1:0] latched_q, latched_d;
   assign terminal = &at_term;
   assign step_req = enable_in & ~clear_in & ~load_in;
   // In saturate mode a terminal step is swallowed, so the digits never move.
   assign step      = step_req & ~(SATURATE & terminal);
   assign carry_out = reset_n_in & step_req & terminal;
   for (genvar k = 0; k < DIGITS; k++) begin : g_digit
      logic en_k;
      if (k == 0) begin : g_first
         assign en_k = step;
      end else begin : g_rest
         assign en_k = step & (&at_term[k-1:0]);
      end
      bcd_digit_updown u_digit (
         .clk_i        (clk_in),
         .rst_n_i      (reset_n_in),
         .clear_i      (clear_in),
         .load_i       (load_in),
         .load_value_i (load_value_in[4*k +: 4]),
         .en_i         (en_k),
         .down_i       (down_in),
         .digit_o      (count_out[4*k +: 4]),
         .at_term_o    (at_term[k])
      );
   end
   always_comb begin
      overflow_d    = (clear_in | load_in) ? 1'b0 : (carry_out | overflow_q);
      latched_d     = latch_in ? count_out : latched_q;
      latched_ovf_d = latch_in ? overflow_q : latched_ovf_q;
   end
   always_ff @(posedge clk_in or negedge reset_n_in) begin
      if (!reset_n_in) begin
         overflow_q    <= 1'b0;
         latched_q     <= '0;
         latched_ovf_q <= 1'b0;
      end else begin
         overflow_q    <= overflow_d;
         latched_q     <= latched_d;
         latched_ovf_q <= latched_ovf_d;
      end
   end
   assign overflow_out         = overflow_q;
   assign latched_out          = latched_q;
   assign latched_overflow_out = latched_ovf_q;
endmodule

// File: doc/counter_bcd_ndigit.md
# counter_bcd_ndigit

Parametrised multi-digit BCD counter: the counting core of the frequency counter. It counts gated input events in decimal. It supports up/down counting, synchronous clear and parallel load, and a wrap or saturate mode with a sticky overflow flag. A snapshot register holds the last gate result stable for the SSD1306 display path while the next gate period counts.

## Interface
- `DIGITS`, default 6: number of BCD digits (1..10); count width is 4*DIGITS.
- `SATURATE`, default 0: 0 = wrap at terminal value, 1 = hold at terminal value.
- `clk_in` (in, 1): single clock; all state changes on its rising edge.
- `reset_n_in` (in, 1): reset; asynchronous, active-low.
- `clear_in` (in, 1): synchronous clear of count and overflow.
- `load_in` (in, 1): synchronous parallel load.
- `load_value_in` (in, 4*DIGITS): BCD value to load; digit 0 in bits [3:0].
- `enable_in` (in, 1): one count step this cycle.
- `down_in` (in, 1): step direction; 0 = +1, 1 = -1.
- `latch_in` (in, 1): capture snapshot.
- `count_out` (out, 4*DIGITS): live BCD count.
- `overflow_out` (out, 1): sticky; set when a step hits or passes the terminal value.
- `carry_out` (out, 1): combinational terminal-step indicator, for cascading.
- `latched_out` (out, 4*DIGITS): snapshot of `count_out`.
- `latched_overflow_out` (out, 1): snapshot of `overflow_out`.

## Operation
- Reset (`reset_n_in`=0, asynchronous): `count_out`, `overflow_out`, `latched_out` and `latched_overflow_out` all go to 0.
- Priority per cycle is `clear_in` > `load_in` > `enable_in`.
- Clear: count goes to 0 and overflow goes to 0.
- Load: count takes `load_value_in` and overflow goes to 0. Any digit >9 is loaded as 0; other digits are unaffected.
- Up step: digit 0 increments. Digit k increments only when all lower digits are 9; a digit at 9 that increments becomes 0.
- Down step: the mirror of up. Digit k decrements only when all lower digits are 0; a digit at 0 that decrements becomes 9.
- Terminal value is all-9 (up) or all-0 (down).
- Step at the terminal value with `SATURATE`=0: count wraps (99..9 to 00..0, or 00..0 to 99..9) and overflow is set.
- Step at the terminal value with `SATURATE`=1: count holds and overflow is set.
- Overflow is not cleared by direction change or by further steps; only reset, clear or load clear it.
- `carry_out` = `reset_n_in` & `enable_in` & !`clear_in` & !`load_in` & (count at the terminal value for the current `down_in`). It is asserted in both modes.
- Latch:
  - `latch_in`=1 copies the registered `count_out` and `overflow_out` into the snapshot registers. These are the values before this cycle's update.
  - When latch and clear occur in the same cycle, the snapshot holds the pre-clear value and the count becomes 0. This is the gate-end idiom.
  - The snapshot is otherwise unchanged by clear, load or enable.

## Timing
- Clear, load and step: result visible on `count_out` one cycle after the qualifying edge.
- Latch: `latched_out` updates one cycle after `latch_in`.
- `carry_out` is combinational from the registered count and the current inputs; there is no registered delay. Consumers sample it on the same edge as `enable_in`.
- One step per enabled cycle; back-to-back `enable_in` gives a full-rate count.
- `down_in` may change every cycle and is sampled with `enable_in`.
- An asynchronous reset assertion mid-count forces all outputs to 0 immediately. Counting resumes on the first edge after deassertion.

## Structure
- Package `bcd_pkg` holds:
  - typedef `bcd_digit_t` (logic [3:0]);
  - constants `BCD_MAX`=4'd9 and `BCD_MIN`=4'd0;
  - function `bcd_sanitize` (digit >9 becomes 0).
- Sub-module `bcd_digit_updown`: one digit with enable, direction, clear and load. It outputs `at_term` (9 when counting up, 0 when counting down).
- The top instantiates `DIGITS` copies in a generate loop. The per-digit enable is an AND-chain of lower `at_term` flags.
- Saturate gating, overflow and snapshot registers live in the top.

## Test plan
- Reset, then enable ×1234 up (`DIGITS`=4) → `count_out`=16'h1234, `overflow_out`=0, `carry_out` never asserted.
- Load 16'h9998, up ×2, `SATURATE`=0 → 9999, then 0000. `carry_out`=1 on the second step; `overflow_out`=1 from the next cycle and stays 1.
- `SATURATE`=1: load 16'h0001, down ×3 → 0000, 0000, 0000. `overflow_out`=1; `carry_out`=1 on the 2nd and 3rd steps.
- Load 16'h0100, one down step → 0099; `load_value_in`=16'h1A3F → `count_out`=16'h1030.
- Count to 0x0042, then `latch_in` with `clear_in` in the same cycle and `enable_in` held → `latched_out`=0042 and `count_out`=0000. Next enabled cycle gives `count_out`=0001.
- Assert `reset_n_in`=0 asynchronously mid-count with `clear_in`, `load_in` and `enable_in` all active → all outputs 0 with no clock edge. Deassert and enable ×1 → `count_out`=1.
